ray_dda_walker: RTL and testbench

Sequential DDA grid walker that casts one ray through the 8x8 tile map by driving the map ROM's address port and reading back tile codes. It is the initiator on the map read interface: it issues `map_addr = {y[2:0], x[2:0]}` and receives a 2-bit tile code with zero-cycle (combinational) latency. An upstream column controller pre-computes the start cell, step signs and Q8.8 side/delta distances for the ray. The walker returns the hit tile, the hit face and the perpendicular wall distance to the renderer.

---
 rtl/wolf_pkg.sv | 26 ++
 rtl/ray_dda_walker_if.sv | 50 +++++
 rtl/sat_add_u.sv | 15 +
 rtl/ray_dda_walker.sv | 184 ++++++++++++++++++
 tb/tb_ray_dda_walker.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wolf_pkg.sv
// rtl/wolf_pkg.sv - shared constants, tile codes and walker state encoding
package wolf_pkg;

  localparam int MAP_LOG2 = 3;

  localparam logic [1:0] TILE_EMPTY = 2'd0;
  localparam logic [1:0] TILE_WALL1 = 2'd1;
  localparam logic [1:0] TILE_WALL2 = 2'd2;
  localparam logic [1:0] TILE_WALL3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } walk_state_e;

  // True when one more step in the given direction would leave the map.
  function automatic logic at_grid_edge(input logic [MAP_LOG2-1:0] coord,
                                        input logic                neg);
    logic [MAP_LOG2-1:0] last;
    last = '1;
    return neg ? (coord == '0) : (coord == last);
  endfunction

endpackage

// File: rtl/ray_dda_walker_if.sv
// rtl/ray_dda_walker_if.sv - ray request, map read port and result bundle
interface ray_dda_walker_if
  import wolf_pkg::*;
#(
  parameter int DIST_W = 16
);

  // Ray request from the column controller
  logic                    start;
  logic [MAP_LOG2-1:0]     map_x0;
  logic [MAP_LOG2-1:0]     map_y0;
  logic                    step_x_neg;
  logic                    step_y_neg;
  logic [DIST_W-1:0]       side_dist_x0;
  logic [DIST_W-1:0]       side_dist_y0;
  logic [DIST_W-1:0]       delta_dist_x;
  logic [DIST_W-1:0]       delta_dist_y;

  // Map ROM read port (combinational data return)
  logic [2*MAP_LOG2-1:0]   map_addr;
  logic [1:0]              map_data;

  // Result towards the renderer
  logic                    busy;
  logic                    done;
  logic [1:0]              hit_tile;
  logic                    hit_side;
  logic [MAP_LOG2-1:0]     hit_x;
  logic [MAP_LOG2-1:0]     hit_y;
  logic [DIST_W-1:0]       perp_dist;

  // Walker side: initiator on the map port, producer of the result
  modport master (
    input  start, map_x0, map_y0, step_x_neg, step_y_neg,
    input  side_dist_x0, side_dist_y0, delta_dist_x, delta_dist_y,
    input  map_data,
    output map_addr,
    output busy, done, hit_tile, hit_side, hit_x, hit_y, perp_dist
  );

  // Environment side: issues rays, serves the map, consumes results
  modport slave (
    output start, map_x0, map_y0, step_x_neg, step_y_neg,
    output side_dist_x0, side_dist_y0, delta_dist_x, delta_dist_y,
    output map_data,
    input  map_addr,
    input  busy, done, hit_tile, hit_side, hit_x, hit_y, perp_dist
  );

endinterface

// File: rtl/sat_add_u.sv
// rtl/sat_add_u.sv - unsigned adder clamped to the all-ones maximum
module sat_add_u #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

// File: rtl/ray_dda_walker.sv
// rtl/ray_dda_walker.sv - sequential DDA walker casting one ray through the 8x8 map
module ray_dda_walker
  import wolf_pkg::*;
#(
  parameter int DIST_W    = 16,
  parameter int MAX_STEPS = 16,
  parameter int STEP_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  ray_dda_walker_if.master  bus
);

  localparam logic [STEP_W-1:0]   LP_MAX_STEPS = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0]   LP_CNT_ONE   = STEP_W'(1);
  localparam logic [MAP_LOG2-1:0] LP_PLUS_ONE  = MAP_LOG2'(1);
  // Adding all-ones is a modular decrement; no subtractor needed.
  localparam logic [MAP_LOG2-1:0] LP_MINUS_ONE = '1;

  walk_state_e           r_state;
  logic [MAP_LOG2-1:0]   r_cur_x;
  logic [MAP_LOG2-1:0]   r_cur_y;
  logic                  r_neg_x;
  logic                  r_neg_y;
  logic [DIST_W-1:0]     r_sdx;
  logic [DIST_W-1:0]     r_sdy;
  logic [DIST_W-1:0]     r_ddx;
  logic [DIST_W-1:0]     r_ddy;
  logic [STEP_W-1:0]     r_step_cnt;
  logic [DIST_W-1:0]     r_perp;
  logic                  r_side;
  logic                  r_busy;
  logic                  r_done;
  logic [1:0]            r_hit_tile;
  logic                  r_hit_side;
  logic [MAP_LOG2-1:0]   r_hit_x;
  logic [MAP_LOG2-1:0]   r_hit_y;
  logic [DIST_W-1:0]     r_perp_dist;

  logic [DIST_W-1:0]     w_sdx_next;
  logic [DIST_W-1:0]     w_sdy_next;
  logic                  w_take_x;
  logic                  w_x_edge;
  logic                  w_y_edge;
  logic                  w_step_leaves;
  logic [MAP_LOG2-1:0]   w_x_next;
  logic [MAP_LOG2-1:0]   w_y_next;

  sat_add_u #(.W(DIST_W)) u_sat_x (
    .i_a   (r_sdx),
    .i_b   (r_ddx),
    .o_sum (w_sdx_next)
  );

  sat_add_u #(.W(DIST_W)) u_sat_y (
    .i_a   (r_sdy),
    .i_b   (r_ddy),
    .o_sum (w_sdy_next)
  );

  // Ties between the two side distances resolve to the x axis.
  assign w_take_x      = (r_sdx <= r_sdy);
  assign w_x_edge      = at_grid_edge(r_cur_x, r_neg_x);
  assign w_y_edge      = at_grid_edge(r_cur_y, r_neg_y);
  assign w_step_leaves = w_take_x ? w_x_edge : w_y_edge;
  assign w_x_next      = r_cur_x + (r_neg_x ? LP_MINUS_ONE : LP_PLUS_ONE);
  assign w_y_next      = r_cur_y + (r_neg_y ? LP_MINUS_ONE : LP_PLUS_ONE);

  assign bus.map_addr  = {r_cur_y, r_cur_x};
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.hit_tile  = r_hit_tile;
  assign bus.hit_side  = r_hit_side;
  assign bus.hit_x     = r_hit_x;
  assign bus.hit_y     = r_hit_y;
  assign bus.perp_dist = r_perp_dist;

  // Walker FSM: alternate STEP (advance one cell) and CHECK (read the tile).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_neg_x     <= 1'b0;
      r_neg_y     <= 1'b0;
      r_sdx       <= '0;
      r_sdy       <= '0;
      r_ddx       <= '0;
      r_ddy       <= '0;
      r_step_cnt  <= '0;
      r_perp      <= '0;
      r_side      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_hit_tile  <= TILE_EMPTY;
      r_hit_side  <= 1'b0;
      r_hit_x     <= '0;
      r_hit_y     <= '0;
      r_perp_dist <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_cur_x    <= bus.map_x0;
            r_cur_y    <= bus.map_y0;
            r_neg_x    <= bus.step_x_neg;
            r_neg_y    <= bus.step_y_neg;
            r_sdx      <= bus.side_dist_x0;
            r_sdy      <= bus.side_dist_y0;
            r_ddx      <= bus.delta_dist_x;
            r_ddy      <= bus.delta_dist_y;
            r_step_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= STEP;
          end
        end

        STEP: begin
          r_step_cnt <= r_step_cnt + LP_CNT_ONE;
          if (w_take_x) begin
            r_side <= 1'b0;
            r_perp <= r_sdx;
            r_sdx  <= w_sdx_next;
            if (!w_x_edge) begin
              r_cur_x <= w_x_next;
            end
          end else begin
            r_side <= 1'b1;
            r_perp <= r_sdy;
            r_sdy  <= w_sdy_next;
            if (!w_y_edge) begin
              r_cur_y <= w_y_next;
            end
          end
          // Leaving the map is a miss; the coordinate stays on the border.
          if (w_step_leaves) begin
            r_hit_tile  <= TILE_EMPTY;
            r_perp_dist <= '1;
            r_hit_side  <= ~w_take_x;
            r_hit_x     <= r_cur_x;
            r_hit_y     <= r_cur_y;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state     <= CHECK;
          end
        end

        CHECK: begin
          if (bus.map_data != TILE_EMPTY) begin
            r_hit_tile  <= bus.map_data;
            r_hit_side  <= r_side;
            r_hit_x     <= r_cur_x;
            r_hit_y     <= r_cur_y;
            r_perp_dist <= r_perp;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end else if (r_step_cnt == LP_MAX_STEPS) begin
            r_hit_tile  <= TILE_EMPTY;
            r_hit_side  <= r_side;
            r_hit_x     <= r_cur_x;
            r_hit_y     <= r_cur_y;
            r_perp_dist <= '1;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state     <= STEP;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dda_walker.sv
// tb/tb_ray_dda_walker.sv - self-checking bench for ray_dda_walker
module tb_ray_dda_walker;

  localparam int TB_MAX = 10;

  typedef struct {
    logic [2:0]  x0;
    logic [2:0]  y0;
    logic        sxn;
    logic        syn;
    logic [15:0] sdx0;
    logic [15:0] sdy0;
    logic [15:0] ddx;
    logic [15:0] ddy;
    int          map_sel;
    logic [1:0]  e_tile;
    logic        e_side;
    logic [2:0]  e_x;
    logic [2:0]  e_y;
    logic [15:0] e_perp;
    int          e_lat;
    bit          chk_side;
  } vec_t;

  logic clk;
  logic rst;
  logic [1:0] map_mem [64];

  int n_cmp;
  int n_bad;

  ray_dda_walker_if #(.DIST_W(16)) ifc ();

  ray_dda_walker #(
    .DIST_W    (16),
    .MAX_STEPS (TB_MAX),
    .STEP_W    (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  assign ifc.map_data = map_mem[ifc.map_addr];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // sel 0: bordered room with one interior wall; 1: empty stub; 2: stub with a wall at (3,1)
  task automatic load_map(input int sel);
    for (int i = 0; i < 64; i++) begin
      int x;
      int y;
      x = i % 8;
      y = i / 8;
      map_mem[i] = 2'd0;
      if (sel == 0) begin
        if (y == 0 || y == 7)      map_mem[i] = 2'd2;
        else if (x == 0 || x == 7) map_mem[i] = 2'd3;
        else if (x == 3 && y == 2) map_mem[i] = 2'd1;
      end else if (sel == 2) begin
        if (x == 3 && y == 1)      map_mem[i] = 2'd2;
      end
    end
  endtask

  // Reference: walk the ray cell by cell with integer distances.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int sx, sy, cx, cy, nx, ny, p;
    bit side;
    r  = v;
    sx = int'(v.sdx0);
    sy = int'(v.sdy0);
    cx = int'(v.x0);
    cy = int'(v.y0);
    r.chk_side = 1'b0;
    for (int n = 1; n <= TB_MAX; n++) begin
      if (sx <= sy) begin
        nx = v.sxn ? cx - 1 : cx + 1;
        if (nx < 0 || nx > 7) begin
          r.e_tile = 2'd0; r.e_perp = 16'hFFFF; r.e_x = 3'(cx); r.e_y = 3'(cy);
          r.e_lat = 2 * n;
          return r;
        end
        p  = sx;
        sx = sx + int'(v.ddx);
        if (sx > 65535) sx = 65535;
        cx = nx;
        side = 1'b0;
      end else begin
        ny = v.syn ? cy - 1 : cy + 1;
        if (ny < 0 || ny > 7) begin
          r.e_tile = 2'd0; r.e_perp = 16'hFFFF; r.e_x = 3'(cx); r.e_y = 3'(cy);
          r.e_lat = 2 * n;
          return r;
        end
        p  = sy;
        sy = sy + int'(v.ddy);
        if (sy > 65535) sy = 65535;
        cy = ny;
        side = 1'b1;
      end
      if (map_mem[cy * 8 + cx] != 2'd0) begin
        r.e_tile = map_mem[cy * 8 + cx]; r.e_perp = 16'(p); r.e_x = 3'(cx); r.e_y = 3'(cy);
        r.e_side = side; r.chk_side = 1'b1; r.e_lat = 2 * n + 1;
        return r;
      end
      if (n == TB_MAX) begin
        r.e_tile = 2'd0; r.e_perp = 16'hFFFF; r.e_x = 3'(cx); r.e_y = 3'(cy);
        r.e_lat = 2 * n + 1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic drive_ray(input vec_t v);
    ifc.map_x0       = v.x0;
    ifc.map_y0       = v.y0;
    ifc.step_x_neg   = v.sxn;
    ifc.step_y_neg   = v.syn;
    ifc.side_dist_x0 = v.sdx0;
    ifc.side_dist_y0 = v.sdy0;
    ifc.delta_dist_x = v.ddx;
    ifc.delta_dist_y = v.ddy;
  endtask

  // Latency counts cycles after the one in which start was sampled.
  task automatic run_walk(input vec_t v, input bit inject, output int lat, output bit busy_ok);
    @(negedge clk);
    drive_ray(v);
    ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (ifc.busy !== 1'b1) busy_ok = 1'b0;
      if (ifc.done === 1'b1) begin
        lat = c;
        break;
      end
      if (inject && c == 2) begin
        ifc.start        = 1'b1;
        ifc.map_x0       = ~v.x0;
        ifc.side_dist_x0 = 16'h0000;
      end
      if (inject && c == 3) ifc.start = 1'b0;
    end
  endtask

  task automatic apply(input vec_t v, input vec_t e, input int idx, input bit inject);
    int lat;
    bit busy_ok;
    run_walk(v, inject, lat, busy_ok);
    chk("latency", idx, 32'(lat), 32'(e.e_lat));
    chk("busy_during", idx, {31'd0, busy_ok}, 32'd1);
    chk("hit_tile", idx, {30'd0, ifc.hit_tile}, {30'd0, e.e_tile});
    chk("hit_x", idx, {29'd0, ifc.hit_x}, {29'd0, e.e_x});
    chk("hit_y", idx, {29'd0, ifc.hit_y}, {29'd0, e.e_y});
    chk("perp_dist", idx, {16'd0, ifc.perp_dist}, {16'd0, e.e_perp});
    if (e.chk_side) chk("hit_side", idx, {31'd0, ifc.hit_side}, {31'd0, e.e_side});
    @(negedge clk);
    chk("done_pulse_end", idx, {31'd0, ifc.done}, 32'd0);
    chk("busy_end", idx, {31'd0, ifc.busy}, 32'd0);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    vec_t e;
    bit saw_done;

    n_cmp = 0;
    n_bad = 0;
    clk = 1'b0;
    rst = 1'b0;
    ifc.start = 1'b0;
    drive_ray('{3'd0, 3'd0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 2'd0, 1'b0, 3'd0, 3'd0, 16'd0, 0, 1'b0});
    load_map(0);

    //          x0    y0    sxn   syn   sdx0      sdy0      ddx       ddy      map tile  side  x     y     perp     lat side?
    vecs[0] = '{3'd1, 3'd2, 1'b0, 1'b0, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF, 0, 2'd1, 1'b0, 3'd3, 3'd2, 16'h0180, 5, 1'b1};
    vecs[1] = '{3'd1, 3'd1, 1'b0, 1'b0, 16'hFFFF, 16'h0080, 16'hFFFF, 16'h0100, 0, 2'd2, 1'b1, 3'd1, 3'd7, 16'h0580, 13, 1'b1};
    vecs[2] = '{3'd5, 3'd4, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 2'd3, 1'b0, 3'd7, 3'd5, 16'h0200, 7, 1'b1};
    vecs[3] = '{3'd6, 3'd3, 1'b0, 1'b0, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 1, 2'd0, 1'b0, 3'd7, 3'd3, 16'hFFFF, 4, 1'b0};
    vecs[4] = '{3'd0, 3'd0, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1, 2'd0, 1'b0, 3'd5, 3'd5, 16'hFFFF, 21, 1'b0};
    vecs[5] = '{3'd1, 3'd1, 1'b0, 1'b0, 16'hFFF0, 16'hFFFF, 16'h0100, 16'hFFFF, 2, 2'd2, 1'b0, 3'd3, 3'd1, 16'hFFFF, 5, 1'b1};
    vecs[6] = '{3'd6, 3'd2, 1'b1, 1'b0, 16'h0040, 16'hFFFF, 16'h0100, 16'hFFFF, 0, 2'd1, 1'b0, 3'd3, 3'd2, 16'h0240, 7, 1'b1};
    vecs[7] = '{3'd4, 3'd3, 1'b0, 1'b1, 16'hFFFF, 16'h0010, 16'hFFFF, 16'h0080, 0, 2'd2, 1'b1, 3'd4, 3'd0, 16'h0110, 7, 1'b1};

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 0, {31'd0, ifc.busy}, 32'd0);
    chk("rst_done", 0, {31'd0, ifc.done}, 32'd0);
    chk("rst_tile", 0, {30'd0, ifc.hit_tile}, 32'd0);
    chk("rst_xyside", 0, {25'd0, ifc.hit_side, ifc.hit_x, ifc.hit_y}, 32'd0);
    chk("rst_perp", 0, {16'd0, ifc.perp_dist}, 32'd0);
    chk("rst_addr", 0, {26'd0, ifc.map_addr}, 32'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      load_map(vecs[i].map_sel);
      apply(vecs[i], vecs[i], i, 1'b0);
    end

    // Start pulsed while busy must not disturb the walk
    load_map(0);
    apply(vecs[1], vecs[1], 100, 1'b1);

    // Asynchronous reset while in CHECK
    run_walk(vecs[0], 1'b0, e.e_lat, saw_done);
    load_map(0);
    @(negedge clk);
    drive_ray(vecs[1]);
    ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 200, {31'd0, ifc.busy}, 32'd0);
    chk("midrst_done", 200, {31'd0, ifc.done}, 32'd0);
    chk("midrst_tile", 200, {30'd0, ifc.hit_tile}, 32'd0);
    chk("midrst_perp", 200, {16'd0, ifc.perp_dist}, 32'd0);
    chk("midrst_addr", 200, {26'd0, ifc.map_addr}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ifc.done === 1'b1 || ifc.busy === 1'b1) saw_done = 1'b1;
    end
    chk("midrst_no_done", 200, {31'd0, saw_done}, 32'd0);
    apply(vecs[0], vecs[0], 201, 1'b0);

    // Randomized rays against the reference model
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 64; i++)
        map_mem[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      v.x0   = 3'($urandom_range(0, 7));
      v.y0   = 3'($urandom_range(0, 7));
      v.sxn  = 1'($urandom_range(0, 1));
      v.syn  = 1'($urandom_range(0, 1));
      v.sdx0 = 16'($urandom);
      v.sdy0 = 16'($urandom);
      v.ddx  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(1, 16'h0400));
      v.ddy  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(1, 16'h0400));
      v.map_sel = 0;
      e = model(v);
      apply(v, e, 300 + k, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
